uart_alu_if: RTL and testbench

UART_ALU_IF -- requirements
Module: uart_alu_if

---
 rtl/uart_alu_if.sv | 176 +++++++++++++++++
 tb/tb_uart_alu_if.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_if.sv
// uart_alu_if
//   Bridges a byte-oriented UART to a combinational ALU. Three received bytes
//   form one frame: operand A, operand B, opcode. After the opcode arrives the
//   ALU result is captured and handed to the UART transmitter. Invalid opcodes
//   and stalled frames are reported with a one-cycle error pulse.
//
// Ports
//   i_clock       single clock, rising edge
//   i_reset       asynchronous, active-high reset
//   i_rx_done     receiver done level (held high for many cycles per byte)
//   i_rx_data     received byte, valid while i_rx_done is high
//   i_alu_result  combinational ALU result for o_data_a/o_data_b/o_opcode
//   i_tx_busy     transmitter busy
//   o_data_a      registered operand A
//   o_data_b      registered operand B
//   o_opcode      registered opcode (low OPCODE_WIDTH bits of the opcode byte)
//   o_tx_start    one-cycle transmit request
//   o_tx_data     byte to transmit
//   o_error       one-cycle pulse on invalid opcode or inter-byte timeout
//   o_state       one-hot FSM state, for observation only
//
// Handshakes
//   Receive: a byte is taken on the rising edge of i_rx_done (registered value
//   0, current value 1); a level held high counts once. Transmit: o_tx_start
//   is issued only in a cycle where i_tx_busy was sampled low; the transfer is
//   considered finished once i_tx_busy has been seen high and then low again.
module uart_alu_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int OPCODE_WIDTH   = 6,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_rx_done,
  input  logic [DATA_WIDTH-1:0]   i_rx_data,
  input  logic [DATA_WIDTH-1:0]   i_alu_result,
  input  logic                    i_tx_busy,
  output logic [DATA_WIDTH-1:0]   o_data_a,
  output logic [DATA_WIDTH-1:0]   o_data_b,
  output logic [OPCODE_WIDTH-1:0] o_opcode,
  output logic                    o_tx_start,
  output logic [DATA_WIDTH-1:0]   o_tx_data,
  output logic                    o_error,
  output logic [5:0]              o_state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  localparam logic [5:0] S_WAIT_A  = 6'b000001;
  localparam logic [5:0] S_WAIT_B  = 6'b000010;
  localparam logic [5:0] S_WAIT_OP = 6'b000100;
  localparam logic [5:0] S_COMPUTE = 6'b001000;
  localparam logic [5:0] S_SEND    = 6'b010000;
  localparam logic [5:0] S_WAIT_TX = 6'b100000;

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(6'b100000);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(6'b100010);
  localparam logic [OPCODE_WIDTH-1:0] OP_AND = OPCODE_WIDTH'(6'b100100);
  localparam logic [OPCODE_WIDTH-1:0] OP_OR  = OPCODE_WIDTH'(6'b100101);
  localparam logic [OPCODE_WIDTH-1:0] OP_XOR = OPCODE_WIDTH'(6'b100110);
  localparam logic [OPCODE_WIDTH-1:0] OP_NOR = OPCODE_WIDTH'(6'b100111);
  localparam logic [OPCODE_WIDTH-1:0] OP_SRA = OPCODE_WIDTH'(6'b000011);
  localparam logic [OPCODE_WIDTH-1:0] OP_SRL = OPCODE_WIDTH'(6'b000010);

  logic [5:0]       state;
  logic             rx_done_q;
  logic             accept;
  logic [CNT_W-1:0] to_cnt;     // inter-byte idle counter (WAIT_B / WAIT_OP)
  logic [CNT_W-1:0] tx_cnt;     // wait for transmitter to pick up the byte
  logic             busy_seen;  // transmitter has gone busy since o_tx_start

  function automatic logic opcode_valid(input logic [OPCODE_WIDTH-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL:
        opcode_valid = 1'b1;
      default:
        opcode_valid = 1'b0;
    endcase
  endfunction

  assign accept  = i_rx_done & ~rx_done_q;
  assign o_state = state;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state      <= S_WAIT_A;
      rx_done_q  <= 1'b0;
      to_cnt     <= '0;
      tx_cnt     <= '0;
      busy_seen  <= 1'b0;
      o_data_a   <= '0;
      o_data_b   <= '0;
      o_opcode   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_error    <= 1'b0;
    end else begin
      // The edge detector always tracks i_rx_done, so bytes that arrive while
      // the frame is being computed or sent are swallowed, not replayed.
      rx_done_q  <= i_rx_done;
      o_tx_start <= 1'b0;
      o_error    <= 1'b0;
      to_cnt     <= '0;
      tx_cnt     <= '0;
      busy_seen  <= 1'b0;

      case (state)
        S_WAIT_A: begin
          if (accept) begin
            o_data_a <= i_rx_data;
            state    <= S_WAIT_B;
          end
        end

        S_WAIT_B: begin
          if (accept) begin
            o_data_b <= i_rx_data;
            state    <= S_WAIT_OP;
          end else if (to_cnt == CNT_MAX) begin
            o_error <= 1'b1;
            state   <= S_WAIT_A;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        S_WAIT_OP: begin
          if (accept) begin
            o_opcode <= i_rx_data[OPCODE_WIDTH-1:0];
            state    <= S_COMPUTE;
          end else if (to_cnt == CNT_MAX) begin
            o_error <= 1'b1;
            state   <= S_WAIT_A;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        // Operands and opcode are already registered, so the ALU result is
        // stable in this cycle.
        S_COMPUTE: begin
          if (opcode_valid(o_opcode)) begin
            o_tx_data <= i_alu_result;
            state     <= S_SEND;
          end else begin
            o_error <= 1'b1;
            state   <= S_WAIT_A;
          end
        end

        S_SEND: begin
          if (!i_tx_busy) begin
            o_tx_start <= 1'b1;
            state      <= S_WAIT_TX;
          end
        end

        // Completion is busy-then-idle; if the transmitter never reacts, give
        // up quietly after TIMEOUT_CYCLES so the link does not lock up.
        S_WAIT_TX: begin
          tx_cnt    <= tx_cnt + 1'b1;
          busy_seen <= busy_seen | i_tx_busy;
          if (busy_seen && !i_tx_busy) begin
            state <= S_WAIT_A;
          end else if (!busy_seen && !i_tx_busy && tx_cnt == CNT_MAX) begin
            state <= S_WAIT_A;
          end
        end

        default: state <= S_WAIT_A;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_if.sv
// tb_uart_alu_if
//   Self-checking bench for uart_alu_if. A small behavioural ALU and a
//   transmitter model surround the DUT; expected results come from the bytes
//   sent and a plain-arithmetic reference of the ALU operations.
module tb_uart_alu_if;

  localparam int DW = 8;
  localparam int OW = 6;
  localparam int TO = 300;

  localparam logic [5:0] ST_WAIT_A  = 6'b000001;
  localparam logic [5:0] ST_WAIT_B  = 6'b000010;
  localparam logic [5:0] ST_WAIT_OP = 6'b000100;
  localparam logic [5:0] ST_SEND    = 6'b010000;
  localparam logic [5:0] ST_WAIT_TX = 6'b100000;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          rx_done = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic [DW-1:0] alu_result;
  logic          tx_busy;
  logic          model_busy = 1'b0;
  logic          hold_busy  = 1'b0;
  logic          tx_mute    = 1'b0;
  logic [DW-1:0] data_a, data_b, tx_data;
  logic [OW-1:0] opcode;
  logic          tx_start, error;
  logic [5:0]    state;

  assign tx_busy = model_busy | hold_busy;

  uart_alu_if #(.DATA_WIDTH(DW), .OPCODE_WIDTH(OW), .TIMEOUT_CYCLES(TO)) dut (
    .i_clock(clk), .i_reset(rst), .i_rx_done(rx_done), .i_rx_data(rx_data),
    .i_alu_result(alu_result), .i_tx_busy(tx_busy),
    .o_data_a(data_a), .o_data_b(data_b), .o_opcode(opcode),
    .o_tx_start(tx_start), .o_tx_data(tx_data), .o_error(error),
    .o_state(state)
  );

  // reference ALU
  logic [5:0] valid_ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};

  function automatic logic [DW-1:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [OW-1:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h03:   return DW'($signed(a) >>> b[2:0]);
      6'h02:   return a >> b[2:0];
      default: return '0;
    endcase
  endfunction

  function automatic bit is_valid(input logic [OW-1:0] op);
    for (int i = 0; i < 8; i++) if (valid_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  assign alu_result = alu_ref(data_a, data_b, opcode);

  // scoreboard
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cnt = 0;
  int err_cnt = 0;
  int clash_cnt = 0;
  int last_start_cyc = 0;
  int last_err_cyc = 0;
  int last_rise_cyc = 0;
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_q[$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (tx_start) begin
      start_cnt = start_cnt + 1;
      got_q.push_back(tx_data);
      last_start_cyc = cyc;
    end
    if (error) begin
      err_cnt = err_cnt + 1;
      last_err_cyc = cyc;
    end
    if (tx_start && error) clash_cnt = clash_cnt + 1;
  end

  // transmitter model: goes busy two cycles after a start, for eight cycles
  always begin
    @(negedge clk);
    if (tx_start && !tx_mute) begin
      repeat (2) @(negedge clk);
      model_busy = 1'b1;
      repeat (8) @(negedge clk);
      model_busy = 1'b0;
    end
  end

  // drivers
  task automatic send_byte(input logic [DW-1:0] b, input int hold);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    last_rise_cyc = cyc;
    repeat (hold) @(negedge clk);
    rx_done = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_frame(input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] opb, input int hold, input string tag);
    logic [OW-1:0] op;
    bit ok;
    int s0, e0;
    logic [DW-1:0] exp_v;
    op = opb[OW-1:0];
    ok = is_valid(op);
    s0 = start_cnt;
    e0 = err_cnt;
    if (ok) exp_q.push_back(alu_ref(a, b, op));
    send_byte(a, hold);
    send_byte(b, hold);
    send_byte(opb, hold);
    repeat (40) @(negedge clk);
    total++; if (data_a !== a) begin bad++; $display("FAIL %s data_a got=%h exp=%h", tag, data_a, a); end
    total++; if (data_b !== b) begin bad++; $display("FAIL %s data_b got=%h exp=%h", tag, data_b, b); end
    total++; if (opcode !== op) begin bad++; $display("FAIL %s opcode got=%h exp=%h", tag, opcode, op); end
    total++; if (start_cnt - s0 != (ok ? 1 : 0)) begin bad++; $display("FAIL %s starts got=%0d exp=%0d", tag, start_cnt - s0, ok ? 1 : 0); end
    total++; if (err_cnt - e0 != (ok ? 0 : 1)) begin bad++; $display("FAIL %s errors got=%0d exp=%0d", tag, err_cnt - e0, ok ? 0 : 1); end
    total++; if (state !== ST_WAIT_A) begin bad++; $display("FAIL %s end_state got=%b exp=%b", tag, state, ST_WAIT_A); end
    if (ok) begin
      exp_v = exp_q.pop_front();
      total++;
      if (start_cnt - s0 != 1 || got_q[got_q.size()-1] !== exp_v) begin
        bad++;
        $display("FAIL %s tx_data got=%h exp=%h", tag, (got_q.size() > 0) ? got_q[got_q.size()-1] : 8'hxx, exp_v);
      end
    end
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (state !== ST_WAIT_A) begin bad++; $display("FAIL reset state got=%b exp=%b", state, ST_WAIT_A); end
    total++; if (data_a !== 8'h00) begin bad++; $display("FAIL reset data_a got=%h exp=00", data_a); end
    total++; if (data_b !== 8'h00) begin bad++; $display("FAIL reset data_b got=%h exp=00", data_b); end
    total++; if (opcode !== 6'h00) begin bad++; $display("FAIL reset opcode got=%h exp=00", opcode); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset tx_data got=%h exp=00", tx_data); end
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL reset tx_start got=%b exp=0", tx_start); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL reset error got=%b exp=0", error); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    run_frame(8'h05, 8'h03, 8'h20, 2, "basic");
    total++; if (tx_data !== 8'h08) begin bad++; $display("FAIL basic tx_data_const got=%h exp=08", tx_data); end
  endtask

  task automatic test_random();
    logic [DW-1:0] opb;
    for (int i = 0; i < 8; i++) begin
      opb = DW'($urandom_range(0, 255));
      opb[OW-1:0] = valid_ops[i];
      run_frame(DW'($urandom), DW'($urandom), opb, $urandom_range(1, 5), "rand_valid");
    end
    for (int i = 0; i < 6; i++) begin
      run_frame(DW'($urandom), DW'($urandom), DW'($urandom), $urandom_range(1, 5), "rand_any");
    end
  endtask

  task automatic test_long_hold();
    logic [DW-1:0] opb;
    opb = {2'b01, valid_ops[$urandom_range(0, 7)]};
    run_frame(DW'($urandom), DW'($urandom), opb, 200, "long_hold");
  endtask

  task automatic test_invalid();
    run_frame(8'h11, 8'h22, 8'h3F, 2, "invalid_3f");
  endtask

  task automatic test_timeout();
    int s0, e0, rise_b, dt;
    s0 = start_cnt;
    e0 = err_cnt;
    send_byte(8'h05, 2);
    send_byte(8'h03, 2);
    rise_b = last_rise_cyc;
    for (int i = 0; i < TO + 20 && err_cnt == e0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    dt = last_err_cyc - rise_b;
    total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL timeout errors got=%0d exp=1", err_cnt - e0); end
    total++; if (dt < TO || dt > TO + 4) begin bad++; $display("FAIL timeout latency got=%0d exp=%0d..%0d", dt, TO, TO + 4); end
    total++; if (start_cnt != s0) begin bad++; $display("FAIL timeout starts got=%0d exp=0", start_cnt - s0); end
    total++; if (state !== ST_WAIT_A) begin bad++; $display("FAIL timeout state got=%b exp=%b", state, ST_WAIT_A); end
    total++; if (data_a !== 8'h05 || data_b !== 8'h03) begin bad++; $display("FAIL timeout operands got=%h/%h exp=05/03", data_a, data_b); end
    run_frame(8'h0C, 8'h0A, 8'h24, 2, "after_timeout");
  endtask

  task automatic test_busy_hold();
    int s0, rel, dt;
    logic [DW-1:0] a, b, exp_v;
    a = DW'($urandom);
    b = DW'($urandom);
    exp_v = alu_ref(a, b, 6'h26);
    s0 = start_cnt;
    hold_busy = 1'b1;
    send_byte(a, 2);
    send_byte(b, 2);
    send_byte(8'h26, 2);
    repeat (3) @(negedge clk);
    send_byte(8'hC3, 2);   // arrives while stuck in SEND, must be dropped
    total++; if (start_cnt != s0) begin bad++; $display("FAIL busy_hold early_start got=%0d exp=0", start_cnt - s0); end
    total++; if (state !== ST_SEND) begin bad++; $display("FAIL busy_hold state got=%b exp=%b", state, ST_SEND); end
    hold_busy = 1'b0;
    rel = cyc;
    for (int i = 0; i < 10 && start_cnt == s0; i++) @(negedge clk);
    dt = last_start_cyc - rel;
    total++; if (start_cnt - s0 != 1) begin bad++; $display("FAIL busy_hold starts got=%0d exp=1", start_cnt - s0); end
    total++; if (dt < 0 || dt > 2) begin bad++; $display("FAIL busy_hold latency got=%0d exp=0..2", dt); end
    repeat (30) @(negedge clk);
    total++; if (start_cnt - s0 != 1) begin bad++; $display("FAIL busy_hold once got=%0d exp=1", start_cnt - s0); end
    total++; if (got_q[got_q.size()-1] !== exp_v) begin bad++; $display("FAIL busy_hold tx_data got=%h exp=%h", got_q[got_q.size()-1], exp_v); end
    total++; if (data_a !== a || state !== ST_WAIT_A) begin bad++; $display("FAIL busy_hold discard got=%h/%b exp=%h/%b", data_a, state, a, ST_WAIT_A); end
    run_frame(8'h40, 8'h02, 8'h22, 2, "after_discard");
  endtask

  task automatic test_tx_timeout();
    int s0, e0;
    s0 = start_cnt;
    e0 = err_cnt;
    tx_mute = 1'b1;
    send_byte(8'h21, 2);
    send_byte(8'h12, 2);
    send_byte(8'h25, 2);
    repeat (5) @(negedge clk);
    total++; if (start_cnt - s0 != 1 || state !== ST_WAIT_TX) begin bad++; $display("FAIL tx_timeout pending got=%0d/%b exp=1/%b", start_cnt - s0, state, ST_WAIT_TX); end
    repeat (TO + 10) @(negedge clk);
    total++; if (state !== ST_WAIT_A) begin bad++; $display("FAIL tx_timeout state got=%b exp=%b", state, ST_WAIT_A); end
    total++; if (err_cnt != e0) begin bad++; $display("FAIL tx_timeout errors got=%0d exp=0", err_cnt - e0); end
    tx_mute = 1'b0;
    got_q.push_back(8'h00);  // keeps got_q aligned only for indexing by last entry
    run_frame(8'h81, 8'h01, 8'h03, 2, "after_tx_timeout");
  endtask

  task automatic test_reset_mid();
    int s0, e0;
    send_byte(8'h77, 2);
    send_byte(8'h66, 2);
    total++; if (state !== ST_WAIT_OP) begin bad++; $display("FAIL reset_mid pre_state got=%b exp=%b", state, ST_WAIT_OP); end
    rst = 1'b1;
    #2;
    total++; if (state !== ST_WAIT_A || data_a !== 8'h00 || data_b !== 8'h00 || opcode !== 6'h00 || tx_data !== 8'h00)
      begin bad++; $display("FAIL reset_mid outputs got=%b/%h/%h/%h/%h exp=%b/00/00/00/00", state, data_a, data_b, opcode, tx_data, ST_WAIT_A); end
    @(negedge clk);
    rst = 1'b0;
    // reset again while waiting in SEND
    s0 = start_cnt;
    e0 = err_cnt;
    hold_busy = 1'b1;
    send_byte(8'h09, 2);
    send_byte(8'h04, 2);
    send_byte(8'h20, 2);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    hold_busy = 1'b0;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    total++; if (start_cnt != s0 || err_cnt != e0) begin bad++; $display("FAIL reset_send pulses got=%0d/%0d exp=0/0", start_cnt - s0, err_cnt - e0); end
    run_frame(8'h30, 8'h05, 8'h02, 2, "after_reset");
  endtask

  task automatic test_rx_at_reset();
    int s0;
    logic [DW-1:0] exp_v;
    s0 = start_cnt;
    exp_v = alu_ref(8'h5A, 8'h0F, 6'h25);
    @(negedge clk);
    rst = 1'b1;
    rx_data = 8'h5A;
    rx_done = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (data_a !== 8'h5A || state !== ST_WAIT_B) begin bad++; $display("FAIL rx_at_reset got=%h/%b exp=5a/%b", data_a, state, ST_WAIT_B); end
    repeat (5) @(negedge clk);
    rx_done = 1'b0;
    repeat (3) @(negedge clk);
    send_byte(8'h0F, 2);
    send_byte(8'h25, 2);
    repeat (40) @(negedge clk);
    total++; if (start_cnt - s0 != 1 || got_q[got_q.size()-1] !== exp_v) begin bad++; $display("FAIL rx_at_reset frame got=%0d/%h exp=1/%h", start_cnt - s0, got_q[got_q.size()-1], exp_v); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_long_hold();
    test_invalid();
    test_random();
    test_timeout();
    test_busy_hold();
    test_tx_timeout();
    test_reset_mid();
    test_rx_at_reset();
    total++; if (clash_cnt != 0) begin bad++; $display("FAIL pulse_overlap got=%0d exp=0", clash_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
